// File: rtl/riscv_pkg.sv
// riscv_pkg: instruction-type and fetch-FSM types, opcode constants and
// opcode classification helpers shared by the front end and the type controller.
package riscv_pkg;

  // Instruction format as seen by the control logic
  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_J = 3'd4,
    TYPE_U = 3'd5
  } inst_type_t;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

  // Base opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct3 values of register-register ops, used by the type controller
  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } R_funct3_t;

  // ALU operation selected by the type controller
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } ALU_func_t;

  // True for every opcode in the supported map (all of them end in 2'b11)
  function automatic logic opcode_known(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM,
      OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Format of a known opcode; unknown ones fall back to I
  function automatic inst_type_t opcode_type(input logic [6:0] opc);
    case (opc)
      OPC_OP:              return TYPE_R;
      OPC_STORE:           return TYPE_S;
      OPC_BRANCH:          return TYPE_B;
      OPC_JAL:             return TYPE_J;
      OPC_LUI, OPC_AUIPC:  return TYPE_U;
      default:             return TYPE_I;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extraction. Only instr[31:7] carries
// immediate bits, so the opcode field is not brought in.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] i_instr,
  input  inst_type_t  i_inst_type,
  output logic [31:0] o_imm
);

  // Assemble and sign-extend the immediate for the given format
  always_comb begin
    o_imm = '0;
    case (i_inst_type)
      TYPE_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      TYPE_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      TYPE_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
      TYPE_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
      TYPE_U: o_imm = {i_instr[31:12], 12'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_fetch_decode.sv
// inst_fetch_decode: fetch sequencer (IDLE/REQ/WAIT/VALID[/HALT]) plus decoder.
// Optional feature macro: ILLEGAL_INST_EN adds the illegal output and HALT.
//
// Handshakes: imem_req is held until imem_gnt; the word arrives later on
// imem_rvalid (only honoured in WAIT). On the decode side an instruction
// transfers on a cycle where dec_valid && dec_ready; while dec_valid is high
// and dec_ready low every decode output holds its value.
module inst_fetch_decode
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output inst_type_t      inst_type,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output fetch_state_t    dbg_state
`ifdef ILLEGAL_INST_EN
  ,
  output logic            illegal
`endif
);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_drop, w_drop_nxt;
  logic            w_latch;
  logic [XLEN-1:0] r_dec_pc;
  inst_type_t      r_type, w_type;
  logic [4:0]      r_rd, r_rs1, r_rs2, w_rd, w_rs1, w_rs2;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [XLEN-1:0] r_imm, w_imm;
  logic            w_known;
  logic [6:0]      w_opcode;
  logic            w_unused_pc_lsb;
`ifdef ILLEGAL_INST_EN
  logic            r_illegal;
`endif

  assign w_opcode        = imem_rdata[6:0];
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  // Classify the incoming word and pick the register fields its format uses
  always_comb begin
    w_known = opcode_known(w_opcode);
    w_type  = w_known ? opcode_type(w_opcode) : TYPE_I;
    w_rd    = imem_rdata[11:7];
    w_rs1   = imem_rdata[19:15];
    w_rs2   = imem_rdata[24:20];
    case (w_type)
      TYPE_I:         w_rs2 = '0;
      TYPE_S, TYPE_B: w_rd  = '0;
      TYPE_J, TYPE_U: begin
        w_rs1 = '0;
        w_rs2 = '0;
      end
      default: ;
    endcase
    // Unknown words become a NOP-like I-type that writes nothing
    if (!w_known) w_rd = '0;
  end

  imm_gen u_imm_gen (
    .i_instr     (imem_rdata[31:7]),
    .i_inst_type (w_type),
    .o_imm       (w_imm)
  );

  // Next-state, next-PC and drop-flag logic; redirect wins over pc+4
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          w_state_nxt = ST_WAIT;
          // Response to the old PC is already in flight
          w_drop_nxt  = redirect;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          w_drop_nxt = 1'b0;
          if (r_drop || redirect) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_VALID;
          end
        end else if (redirect) begin
          w_drop_nxt = 1'b1;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          w_state_nxt = ST_REQ;
        end else if (dec_ready) begin
          w_pc_nxt = r_pc + XLEN'(4);
`ifdef ILLEGAL_INST_EN
          w_state_nxt = r_illegal ? ST_HALT : ST_REQ;
`else
          w_state_nxt = ST_REQ;
`endif
        end
      end
      ST_HALT: begin
        if (redirect) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (redirect) w_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
  end

  // State, PC and decoded-instruction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_drop    <= 1'b0;
      r_dec_pc  <= '0;
      r_type    <= TYPE_R;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_imm     <= '0;
`ifdef ILLEGAL_INST_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      if (w_latch) begin
        r_dec_pc  <= r_pc;
        r_type    <= w_type;
        r_rd      <= w_rd;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_funct3  <= imem_rdata[14:12];
        r_funct7  <= imem_rdata[31:25];
        r_imm     <= w_imm;
`ifdef ILLEGAL_INST_EN
        r_illegal <= !w_known;
`endif
      end
    end
  end

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = imem_req ? r_pc : '0;
  assign dec_valid = (r_state == ST_VALID);
  assign dec_pc    = r_dec_pc;
  assign inst_type = r_type;
  assign rd        = r_rd;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign funct3    = r_funct3;
  assign funct7    = r_funct7;
  assign imm       = r_imm;
  assign dbg_state = r_state;
`ifdef ILLEGAL_INST_EN
  assign illegal   = r_illegal && dec_valid;
`endif

endmodule

// File: tb/tb_inst_fetch_decode.sv
// tb_inst_fetch_decode: table vectors, hand sequences for redirect/reset/stall
// corners, then randomized fetches checked against a format-rule model.
module tb_inst_fetch_decode;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2,
                         T_B = 3'd3, T_J = 3'd4, T_U = 3'd5;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc;
  logic [2:0]  inst_type;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [2:0]  dbg_state;
`ifdef ILLEGAL_INST_EN
  logic        illegal;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  inst_fetch_decode dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .inst_type(inst_type), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .dbg_state(dbg_state)
`ifdef ILLEGAL_INST_EN
    , .illegal(illegal)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic [2:0] t,
                              input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] i);
    vec_t v;
    v.word = w; v.typ = t; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = i;
    return v;
  endfunction

  // Reference decode from the format rules, using shifts and masks on the word
  function automatic vec_t ref_decode(input logic [31:0] w);
    vec_t e;
    logic [31:0] sx;
    sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
    e.word = w;
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    case (w[6:0])
      7'h33: begin e.typ = T_R; e.imm = 32'h0; end
      7'h13, 7'h03, 7'h67, 7'h73: begin
        e.typ = T_I; e.rs2 = 5'd0; e.imm = 32'($signed(w) >>> 20);
      end
      7'h23: begin
        e.typ = T_S; e.rd = 5'd0;
        e.imm = 32'($signed(w) >>> 25) * 32'd32 + ((w >> 7) & 32'd31);
      end
      7'h63: begin
        e.typ = T_B; e.rd = 5'd0;
        e.imm = (sx & ~32'hFFF) | (((w >> 7) & 32'd1) << 11) |
                (((w >> 25) & 32'd63) << 5) | (((w >> 8) & 32'd15) << 1);
      end
      7'h6F: begin
        e.typ = T_J; e.rs1 = 5'd0; e.rs2 = 5'd0;
        e.imm = (sx & 32'hFFF0_0000) | (w & 32'h000F_F000) |
                (((w >> 20) & 32'd1) << 11) | (((w >> 21) & 32'd1023) << 1);
      end
      7'h37, 7'h17: begin
        e.typ = T_U; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = w & 32'hFFFF_F000;
      end
      default: begin
        e.typ = T_I; e.rd = 5'd0; e.rs2 = 5'd0; e.imm = 32'($signed(w) >>> 20);
      end
    endcase
    return e;
  endfunction

  // Compare all decode outputs against an expected record
  task automatic check_dec(input vec_t e, input logic [31:0] pc);
    check("dec_valid", {31'd0, dec_valid}, 32'd1);
    check("dec_pc", dec_pc, pc);
    check("inst_type", {29'd0, inst_type}, {29'd0, e.typ});
    check("rd", {27'd0, rd}, {27'd0, e.rd});
    check("rs1", {27'd0, rs1}, {27'd0, e.rs1});
    check("rs2", {27'd0, rs2}, {27'd0, e.rs2});
    check("funct3", {29'd0, funct3}, (e.word >> 12) & 32'd7);
    check("funct7", {25'd0, funct7}, e.word >> 25);
    check("imm", imm, e.imm);
  endtask

  // Memory driver: serve one request up to the point the decode is visible
  task automatic fetch_to_valid(input vec_t e, input logic [31:0] pc,
                                input int gd, input int rdl);
    int t;
    t = 0;
    while (!imem_req && t < 20) begin
      tick();
      t++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    check("imem_addr", imem_addr, pc);
    repeat (gd) tick();
    if (gd > 0) check("req_hold", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    repeat (rdl) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = e.word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    check_dec(e, pc);
  endtask

  // Full transaction with a consumer stall of rdy cycles
  task automatic fetch_one(input vec_t e, input logic [31:0] pc,
                           input int gd, input int rdl, input int rdy);
    fetch_to_valid(e, pc, gd, rdl);
    repeat (rdy) begin
      tick();
      check_dec(e, pc);
      check("no_req_stall", {31'd0, imem_req}, 32'd0);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("valid_after_xfer", {31'd0, dec_valid}, 32'd0);
  endtask

  vec_t        tbl[9];
  logic [6:0]  opcs[11];
  int          n_opc;
  logic [31:0] pc;
  logic [31:0] w;
  vec_t        e;

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

    tbl[0] = mk(32'h0050_0093, T_I, 5'd1, 5'd0, 5'd0, 32'd5);
    tbl[1] = mk(32'hFE20_AE23, T_S, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    tbl[2] = mk(32'hFE00_0EE3, T_B, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    tbl[3] = mk(32'h0080_006F, T_J, 5'd0, 5'd0, 5'd0, 32'd8);
    tbl[4] = mk(32'h1234_5037, T_U, 5'd0, 5'd0, 5'd0, 32'h1234_5000);
    tbl[5] = mk(32'h0020_81B3, T_R, 5'd3, 5'd1, 5'd2, 32'd0);
    tbl[6] = mk(32'hFFFF_F097, T_U, 5'd1, 5'd0, 5'd0, 32'hFFFF_F000);
    tbl[7] = mk(32'h0081_2283, T_I, 5'd5, 5'd2, 5'd0, 32'd8);
    tbl[8] = mk(32'h0000_0073, T_I, 5'd0, 5'd0, 5'd0, 32'd0);

    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03; opcs[3] = 7'h67;
    opcs[4] = 7'h73; opcs[5] = 7'h23; opcs[6] = 7'h63; opcs[7] = 7'h6F;
    opcs[8] = 7'h37; opcs[9] = 7'h17; opcs[10] = 7'h0B;
`ifdef ILLEGAL_INST_EN
    n_opc = 10;
`else
    n_opc = 11;
`endif

    // Reset state
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_type", {29'd0, inst_type}, {29'd0, T_R});
    check("rst_rd", {27'd0, rd}, 32'd0);
    check("rst_imm", imm, 32'd0);
    reset = 1'b1;

    // Table vectors: gnt same cycle first, 4-cycle stall on the store
    pc = 32'd0;
    for (int i = 0; i < 9; i++) begin
      fetch_one(tbl[i], pc, i % 3, (i == 0) ? 0 : i % 2, (i == 1) ? 4 : i % 2);
      pc = pc + 32'd4;
    end

`ifndef ILLEGAL_INST_EN
    // Unknown opcode decodes as I-type with rd forced to 0, fetch continues
    fetch_one(mk(32'h0000_048B, T_I, 5'd0, 5'd0, 5'd0, 32'd0), pc, 0, 0, 0);
    pc = pc + 32'd4;
`endif

    // Redirect while waiting for the response: response dropped
    fetch_to_valid_skip: begin
      int t;
      t = 0;
      while (!imem_req && t < 20) begin tick(); t++; end
      check("w_req", {31'd0, imem_req}, 32'd1);
      check("w_addr", imem_addr, pc);
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0000_0103; tick(); redirect = 1'b0;
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; tick(); imem_rvalid = 1'b0;
      check("drop_valid", {31'd0, dec_valid}, 32'd0);
      check("drop_req", {31'd0, imem_req}, 32'd1);
      check("drop_addr", imem_addr, 32'h0000_0100);
      tick();
      check("drop_valid2", {31'd0, dec_valid}, 32'd0);
    end
    pc = 32'h100;
    fetch_one(tbl[5], pc, 1, 1, 0);
    pc = pc + 32'd4;

    // Stray rvalid in REQ ignored, then redirect before grant
    imem_rvalid = 1'b1; tick(); imem_rvalid = 1'b0;
    check("stray_valid", {31'd0, dec_valid}, 32'd0);
    check("stray_req", {31'd0, imem_req}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; tick(); redirect = 1'b0;
    check("req_redir_addr", imem_addr, 32'h0000_0200);
    pc = 32'h200;
    fetch_one(tbl[0], pc, 0, 0, 0);
    pc = pc + 32'd4;

    // Redirect in VALID squashes even with dec_ready=1; then PC wrap
    fetch_to_valid(tbl[3], pc, 0, 0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; dec_ready = 1'b1;
    tick();
    redirect = 1'b0; dec_ready = 1'b0;
    check("squash_valid", {31'd0, dec_valid}, 32'd0);
    check("squash_req", {31'd0, imem_req}, 32'd1);
    check("squash_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_one(tbl[4], 32'hFFFF_FFFC, 0, 0, 0);
    fetch_one(tbl[6], 32'h0000_0000, 0, 0, 0);

    // Async reset mid-stall in VALID
    fetch_to_valid(tbl[1], 32'h4, 0, 0);
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, dec_valid}, 32'd0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_imm", imm, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    fetch_one(tbl[7], 32'h0, 0, 0, 0);
    pc = 32'h4;

    // Randomized fetches against the reference model
    for (int n = 0; n < 40; n++) begin
      w = $urandom();
      w[6:0] = opcs[$urandom_range(0, n_opc - 1)];
      e = ref_decode(w);
      exp_q.push_back(pc);
      if ($urandom_range(0, 4) == 0) begin
        fetch_to_valid(e, exp_q.pop_front(), $urandom_range(0, 2), $urandom_range(0, 2));
        redirect = 1'b1; redirect_pc = $urandom(); dec_ready = $urandom_range(0, 1) == 1;
        pc = redirect_pc & 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; dec_ready = 1'b0;
        check("rnd_squash", {31'd0, dec_valid}, 32'd0);
      end else begin
        fetch_one(e, exp_q.pop_front(), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 3));
        pc = pc + 32'd4;
      end
    end

`ifdef ILLEGAL_INST_EN
    // Illegal word: flagged with dec_valid, then halt until redirect
    fetch_to_valid(ref_decode(32'hFFFF_FFFF), pc, 0, 0);
    check("illegal", {31'd0, illegal}, 32'd1);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    repeat (5) begin
      tick();
      check("halt_no_req", {31'd0, imem_req}, 32'd0);
    end
    redirect = 1'b1; redirect_pc = 32'h40; tick(); redirect = 1'b0;
    check("halt_exit_req", {31'd0, imem_req}, 32'd1);
    check("halt_exit_addr", imem_addr, 32'h40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
